// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 framing types and constants for tx and check sides
package crc_pkg;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h55;
  localparam int         DATA_W_DEFAULT    = 64;
  localparam int         CRC_W             = 8;
  localparam int         FRAME_LEN         = DATA_W_DEFAULT + CRC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/crc8_step.sv
// rtl/crc8_step.sv - one serial step of an MSB-first CRC-8 LFSR
module crc8_step
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_next
);

  logic fb;

  // Feedback is the outgoing CRC MSB folded with the incoming message bit
  always_comb begin
    fb       = crc_in[7] ^ bit_in;
    crc_next = {crc_in[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

endmodule

// File: rtl/crc_frame_tx.sv
// rtl/crc_frame_tx.sv - serialises a payload MSB first followed by its CRC-8 (optional CRC_FRAME_TX_STALL_EN)
module crc_frame_tx
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY   = CRC8_POLY_DEFAULT,
  parameter int         DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
`ifdef CRC_FRAME_TX_STALL_EN
  input  logic              tx_ready,
`endif
  output logic [7:0]        crc_out,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + CRC_W);

  tx_state_e         state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [7:0]        crc_reg;
  logic [7:0]        crc_step_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              accept;
  logic              xfer;
  logic              data_end;
  logic              crc_end;

`ifdef CRC_FRAME_TX_STALL_EN
  assign xfer = tx_valid && tx_ready;
`else
  assign xfer = tx_valid;
`endif

  assign accept   = in_valid && in_ready;
  assign data_end = (state == ST_DATA) && xfer && (bit_cnt == CNT_W'(DATA_W - 1));
  assign crc_end  = (state == ST_CRC)  && xfer && (bit_cnt == CNT_W'(CRC_W - 1));

  crc8_step #(.POLY(POLY)) u_step (
    .crc_in   (crc_reg),
    .bit_in   (shreg[DATA_W-1]),
    .crc_next (crc_step_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: payload bits, then CRC bits, then a single done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)   state_nxt = ST_DATA;
      ST_DATA: if (data_end) state_nxt = ST_CRC;
      ST_CRC:  if (crc_end)  state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; serial outputs are forced low when not valid
  always_comb begin
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_last  = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_bit   = shreg[DATA_W-1];
      end
      ST_CRC: begin
        tx_valid = 1'b1;
        tx_bit   = crc_reg[7];
        tx_last  = (bit_cnt == CNT_W'(CRC_W - 1));
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: everything advances only on a transferred bit, so a stall freezes it
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      crc_reg <= '0;
      bit_cnt <= '0;
      crc_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= data_in;
            crc_reg <= '0;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            crc_reg <= crc_step_nxt;
            if (data_end) begin
              bit_cnt <= '0;
              crc_out <= crc_step_nxt;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_CRC: begin
          if (xfer) begin
            crc_reg <= {crc_reg[6:0], 1'b0};
            bit_cnt <= crc_end ? '0 : bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_tx.sv
// tb/tb_crc_frame_tx.sv - directed and model-checked bench for crc_frame_tx
module tb_crc_frame_tx;

  localparam logic [7:0] POLY = 8'h55;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic [7:0]  crc_out;
  logic        done;

  int checks   = 0;
  int failures = 0;
  bit stall_on = 1'b0;

  crc_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
`ifdef CRC_FRAME_TX_STALL_EN
    .tx_ready (tx_ready),
`endif
    .crc_out  (crc_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Long division of a frame by x^8 + POLY
  function automatic logic [7:0] mod_gen(input logic [71:0] f);
    logic [71:0] r;
    r = f;
    for (int i = 71; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, POLY};
    return r[7:0];
  endfunction

  // Offer one payload from a negedge in IDLE and collect the frame until done
  task automatic send_frame(input logic [63:0] d, input bit hold,
                            output logic [71:0] fr, output int nbits, output int last_idx,
                            output int done_at, output int rdy_hi, output int err);
    int   cyc;
    bit   prev_stalled;
    logic prev_bit, prev_last;
    fr = '0; nbits = 0; last_idx = -1; done_at = -1; rdy_hi = 0; err = 0;
    prev_stalled = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    data_in = ~d;
    if (!hold) in_valid = 1'b0;
    while (cyc < 400 && done_at < 0) begin
      tx_ready = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stalled && (!tx_valid || tx_bit !== prev_bit || tx_last !== prev_last)) err++;
      if (!tx_valid && (tx_bit !== 1'b0 || tx_last !== 1'b0)) err++;
      if (in_ready) rdy_hi++;
      if (tx_valid && tx_ready) begin
        if (nbits < 72) fr[71 - nbits] = tx_bit;
        if (tx_last) last_idx = nbits;
        nbits++;
      end
      if (done) done_at = cyc;
      prev_stalled = tx_valid && !tx_ready;
      prev_bit     = tx_bit;
      prev_last    = tx_last;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b1;
    if (done_at < 0) check("frame_timeout", 1'b1, 1'b0);
  endtask

  logic [71:0] fr;
  int          nb, li, da, rh, er;
  logic [63:0] d;
  logic [7:0]  exp_crc;
  int          seen;

  initial begin
    rst = 1'b1; data_in = '0; in_valid = 1'b0; tx_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_bit",   tx_bit,   1'b0);
    check("rst_tx_last",  tx_last,  1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_crc_out",  crc_out,  8'h00);
    rst = 1'b0;
    @(negedge clk);

    send_frame(64'h0, 1'b0, fr, nb, li, da, rh, er);
    check("zero_frame",  fr, 72'h0);
    check("zero_crc",    crc_out, 8'h00);
    check("zero_done",   da, 73);
    check("zero_nbits",  nb, 72);
    check("zero_last",   li, 71);
    check("zero_ready",  rh, 0);
    check("zero_idle",   er, 0);

    send_frame(64'h1, 1'b0, fr, nb, li, da, rh, er);
    check("one_crc",     crc_out, 8'h55);
    check("one_frame",   fr, {64'h1, 8'h55});
    check("one_last",    li, 71);
    check("one_done",    da, 73);

    send_frame(64'h2, 1'b0, fr, nb, li, da, rh, er);
    check("two_crc",     crc_out, 8'hAA);
    check("two_frame",   fr, {64'h2, 8'hAA});

    // in_valid held high across three frames: each is accepted exactly once
    send_frame(64'h1, 1'b1, fr, nb, li, da, rh, er);
    check("b2b0_crc",  crc_out, 8'h55);
    check("b2b0_done", da, 73);
    check("b2b0_rdy",  rh, 0);
    send_frame(64'h3, 1'b1, fr, nb, li, da, rh, er);
    check("b2b1_crc",   crc_out, 8'hFF);
    check("b2b1_frame", fr, {64'h3, 8'hFF});
    check("b2b1_done",  da, 73);
    check("b2b1_nbits", nb, 72);
    send_frame(64'h2, 1'b1, fr, nb, li, da, rh, er);
    check("b2b2_crc",  crc_out, 8'hAA);
    check("b2b2_done", da, 73);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset during bit 30, with a simultaneous offer on the reset edge
    send_frame(64'h3, 1'b0, fr, nb, li, da, rh, er);
    check("pre_rst_crc", crc_out, 8'hFF);
    data_in = 64'hDEAD_BEEF_0123_4567; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 30; i++) begin
      if (tx_valid) seen++;
      if (seen < 30) @(negedge clk);
    end
    check("rst_reached_bit30", seen, 30);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_tx_valid", tx_valid, 1'b0);
    check("abort_done",     done,     1'b0);
    check("abort_crc_out",  crc_out,  8'h00);
    @(posedge clk); @(negedge clk);
    check("abort_rst_wins", tx_valid, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || tx_valid) seen++;
    end
    check("abort_no_resume", seen, 0);
    send_frame(64'h2, 1'b0, fr, nb, li, da, rh, er);
    check("post_rst_crc",   crc_out, 8'hAA);
    check("post_rst_frame", fr, {64'h2, 8'hAA});
    check("post_rst_done",  da, 73);

    // Random payloads against the long-division model
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom};
      exp_crc = mod_gen({d, 8'h00});
      send_frame(d, 1'b0, fr, nb, li, da, rh, er);
      check("rnd_crc",     crc_out, exp_crc);
      check("rnd_payload", fr[71:8], d);
      check("rnd_rem",     mod_gen(fr), 8'h00);
      check("rnd_shape",   {da[7:0], nb[7:0], li[7:0], er[7:0]}, {8'd73, 8'd72, 8'd71, 8'd0});
    end

`ifdef CRC_FRAME_TX_STALL_EN
    // Random back-pressure must not change the frame or the CRC
    stall_on = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom};
      exp_crc = mod_gen({d, 8'h00});
      send_frame(d, 1'b0, fr, nb, li, da, rh, er);
      check("stall_crc",    crc_out, exp_crc);
      check("stall_frame",  fr, {d, exp_crc});
      check("stall_stable", er, 0);
      check("stall_last",   li, 71);
    end
    stall_on = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_frame_tx.md
CRC_FRAME_TX -- requirements
Module: crc_frame_tx

Interface
REQ-001 Parameter POLY, default 8'h55, generator low byte; generator = x^8 + POLY, i.e. x^8+x^6+x^4+x^2+1 by default.
REQ-002 Parameter DATA_W, default 64, payload width in bits; frame length = DATA_W+8.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  DATA_W  payload; sampled only on accept.
REQ-006 in_valid  input  1  payload offered.
REQ-007 in_ready  output  1  block can accept; high only in IDLE.
REQ-008 tx_bit  output  1  serial frame bit, MSB first.
REQ-009 tx_valid  output  1  tx_bit valid this cycle.
REQ-010 tx_last  output  1  marks final frame bit (CRC bit 0).
REQ-011 tx_ready  input  1  sink accepts tx_bit; present only with CRC_FRAME_TX_STALL_EN.
REQ-012 crc_out  output  8  CRC of last payload; held until next update.
REQ-013 done  output  1  one-cycle pulse after final bit transferred.

Function
REQ-014 States IDLE, DATA, CRC, DONE; encoding from package.
REQ-015 Accept = in_valid && in_ready in IDLE; data_in captured into a DATA_W shift register, crc_reg cleared to 8'h00, bit counter cleared, next state DATA.
REQ-016 in_valid outside IDLE is ignored; no queuing.
REQ-017 DATA: tx_valid=1, tx_bit = shift register MSB (data_in[DATA_W-1] first); per transferred bit, fb = crc_reg[7] ^ tx_bit, crc_reg <= (crc_reg<<1) ^ (fb ? POLY : 8'h00), shift register shifts left.
REQ-018 Result SHALL equal remainder of payload*x^8 mod generator, init 0, no reflection, no final XOR.
REQ-019 After DATA_W transferred bits: crc_out <= final crc_reg (same edge as entering CRC), next state CRC.
REQ-020 CRC: tx_valid=1, tx_bit = crc_reg[7], crc_reg shifts left with zero fill, no feedback; 8 bits, tx_last=1 on the 8th.
REQ-021 After last bit transfers: next state DONE; DONE drives done=1, tx_valid=0 for one cycle, then IDLE.
REQ-022 Without stall: accept at edge T, frame bits in cycles T+1..T+DATA_W+8, done in cycle T+DATA_W+9, in_ready high again in cycle T+DATA_W+10.
REQ-023 Bit counter width ceil(log2(DATA_W+8)); no wrap within a frame.
REQ-024 In IDLE/DONE: tx_valid=0, tx_bit=0, tx_last=0.

Reset
REQ-025 rst high at an edge: state IDLE, crc_reg 0, counter 0, shift register 0, crc_out 8'h00, done 0, tx_valid 0, in_ready 1 next cycle.
REQ-026 rst mid-frame aborts; no done, crc_out reset to 0, no partial frame resumes; rst wins over simultaneous accept.

Configuration
REQ-027 CRC_FRAME_TX_STALL_EN defined: tx_ready port present; a bit transfers only when tx_valid && tx_ready; tx_bit/tx_last/state held stable while tx_ready=0.
REQ-028 CRC_FRAME_TX_STALL_EN undefined: no tx_ready port; every tx_valid cycle is a transfer; timing per REQ-022.

Structure
REQ-029 Package crc_pkg: state enum, CRC8_POLY_DEFAULT=8'h55, DATA_W default 64, FRAME_LEN=72; shared with the CRC checking side.
REQ-030 One combinational sub-module crc8_step (crc, bit, POLY -> next crc) used in DATA state; nothing else split out.

Verification
REQ-031 data_in=64'h0 -> 72 zero bits, crc_out=8'h00, done at T+73.
REQ-032 data_in=64'h1 -> crc_out=8'h55, last 8 bits 0,1,0,1,0,1,0,1 with tx_last on final; data_in=64'h2 -> crc_out=8'hAA.
REQ-033 Random payloads x1000: reassemble 72-bit stream, bench model remainder of full frame mod generator = 8'h00, payload bits match data_in MSB first.
REQ-034 in_valid held high continuously -> frames back-to-back, one accept per frame, in_valid during DATA/CRC/DONE ignored.
REQ-035 rst asserted at bit 30 -> tx_valid=0 next cycle, no done, crc_out=0; next accept produces correct full frame.
REQ-036 With CRC_FRAME_TX_STALL_EN, random tx_ready (50%) -> identical bit sequence and crc_out as no-stall run; outputs stable while stalled.
